// File: rtl/test_status_reporter.sv
// rtl/test_status_reporter.sv - Wishbone test-progress reporter driving success level and next-test pulse pads
//
// Firmware reports directed-test progress to the off-chip bench through two
// pads: a success level and a train of next-test pulses whose rising edges the
// bench counts. Pulse requests are queued in a saturating counter so that
// back-to-back requests each produce one distinct rising edge, separated by a
// guaranteed low gap.
//
// Register map (word offset):
//   0 CONTROL  bit0 SUCCESS (RW), bit1 NEXT (W1, reads 0), bit2 CLEAR (W1, reads 0)
//              writes apply only when wb_sel_i[0] is set
//   1 STATUS   bit0 BUSY, bit1 OVERFLOW (sticky), [7:4] PENDING, [31:16] TEST_COUNT
//   2, 3       read 0, writes ignored but acknowledged
//
// Ports:
//   wb_clk_i     clock
//   wb_rst_i     asynchronous active-high reset
//   wb_cyc_i     bus cycle
//   wb_stb_i     strobe
//   wb_we_i      write enable
//   wb_sel_i     byte lane select (only lane 0 carries CONTROL bits)
//   wb_adr_i     word offset within the block
//   wb_dat_i     write data
//   wb_ack_o     one-cycle acknowledge, the cycle after the request is seen
//   wb_dat_o     read data, valid with wb_ack_o and zero otherwise
//   success_o    success level to pad
//   next_test_o  test-advance pulse to pad

module test_status_reporter #(
    parameter int PULSE_CYCLES = 8,
    parameter int MAX_PENDING  = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        success_o,
    output logic        next_test_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] PEND_MAX   = 4'(MAX_PENDING);
    localparam logic [7:0] PHASE_LAST = 8'(PULSE_CYCLES - 1);

    localparam logic [1:0] ADR_CONTROL = 2'd0;
    localparam logic [1:0] ADR_STATUS  = 2'd1;

    state_t      state;
    logic [7:0]  phase_cnt;
    logic [3:0]  pending;
    logic        overflow;
    logic [15:0] test_count;

    logic        req;
    logic        wr_ctrl;
    logic        do_next;
    logic        do_clear;
    logic        dequeue;
    logic        busy;
    logic [31:0] rd_data;

    // Only lane-0 CONTROL bits are used; the remaining write data is ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, wb_dat_i[31:3], wb_sel_i[3:1]};

    // A request is only seen while no acknowledge is outstanding, so a master
    // holding cyc/stb gets one ack per two cycles and never a double commit.
    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_ctrl  = req & wb_we_i & (wb_adr_i == ADR_CONTROL) & wb_sel_i[0];
    assign do_next  = wr_ctrl & wb_dat_i[1];
    assign do_clear = wr_ctrl & wb_dat_i[2];
    assign busy     = (state != IDLE);

    // The FSM takes a queued request either from IDLE or at the very end of
    // the low gap, which is what keeps rising edges 2*PULSE_CYCLES apart.
    assign dequeue = (pending != 4'd0) &&
                     ((state == IDLE) || ((state == GAP) && (phase_cnt == 8'd0)));

    always_comb begin
        rd_data = 32'h0000_0000;
        case (wb_adr_i)
            ADR_CONTROL: rd_data = {31'h0, success_o};
            ADR_STATUS:  rd_data = {test_count, 8'h00, pending, 2'b00, overflow, busy};
            default:     rd_data = 32'h0000_0000;
        endcase
    end

    // Bus side: ack, read data and the SUCCESS level all commit on the edge
    // that raises the ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= 32'h0000_0000;
            success_o <= 1'b0;
        end else begin
            wb_ack_o <= req;
            if (req && !wb_we_i) begin
                wb_dat_o <= rd_data;
            end else begin
                wb_dat_o <= 32'h0000_0000;
            end
            if (wr_ctrl) begin
                success_o <= wb_dat_i[0];
            end
        end
    end

    // Request queue. A request arriving on the dequeue edge cancels out; a
    // request that finds the queue full (and not draining) is dropped and
    // flagged. A fresh overflow event outranks a CLEAR in the same write.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pending  <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (do_next && !dequeue) begin
                if (pending == PEND_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    pending  <= pending + 4'd1;
                    if (do_clear) begin
                        overflow <= 1'b0;
                    end
                end
            end else begin
                if (dequeue && !do_next) begin
                    pending <= pending - 4'd1;
                end
                if (do_clear) begin
                    overflow <= 1'b0;
                end
            end
        end
    end

    // Completed-request counter; CLEAR beats a simultaneous increment.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            test_count <= 16'h0000;
        end else if (do_clear) begin
            test_count <= 16'h0000;
        end else if (dequeue) begin
            test_count <= test_count + 16'h0001;
        end
    end

    // Pulse FSM. phase_cnt counts down the cycles left in HIGH or GAP; the
    // pad output is registered alongside the state so it has no input path.
    // Because pending only becomes non-zero on the commit edge, next_test_o
    // rises one edge after success_o when both are written together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            phase_cnt   <= 8'd0;
            next_test_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    next_test_o <= 1'b0;
                    if (dequeue) begin
                        state       <= HIGH;
                        phase_cnt   <= PHASE_LAST;
                        next_test_o <= 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_cnt == 8'd0) begin
                        state       <= GAP;
                        phase_cnt   <= PHASE_LAST;
                        next_test_o <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (phase_cnt == 8'd0) begin
                        if (dequeue) begin
                            state       <= HIGH;
                            phase_cnt   <= PHASE_LAST;
                            next_test_o <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    phase_cnt   <= 8'd0;
                    next_test_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_status_reporter.sv
// tb/tb_test_status_reporter.sv - self-checking bench for test_status_reporter

module tb_test_status_reporter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [1:0]  wb_adr_i = 2'd0;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        success_o;
    logic        next_test_o;

    test_status_reporter #(.PULSE_CYCLES(8), .MAX_PENDING(15)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_o    (wb_ack_o),
        .wb_dat_o    (wb_dat_o),
        .success_o   (success_o),
        .next_test_o (next_test_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge wb_clk_i) cyc++;

    // Pulse monitor: cycle number of every rising edge and length of every high phase.
    int   rise_q[$];
    int   hi_q[$];
    int   hi_len  = 0;
    logic nt_prev = 1'b0;

    always @(negedge wb_clk_i) begin
        if (next_test_o && !nt_prev) rise_q.push_back(cyc);
        if (next_test_o) begin
            hi_len++;
        end else if (nt_prev) begin
            hi_q.push_back(hi_len);
            hi_len = 0;
        end
        nt_prev = next_test_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdata, output int ack_at);
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        ack_at   = -1;
        rdata    = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wb_ack_o) begin
                ack_at = cyc;
                rdata  = wb_dat_o;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        check("ack_seen", 32'(ack_at >= 0), 32'd1);
    endtask

    task automatic wr(input logic [31:0] dat, output int ack_at);
        logic [31:0] rd;
        xfer(1'b1, 2'd0, dat, 4'hF, rd, ack_at);
    endtask

    task automatic rd_status(input string name, input logic [31:0] exp);
        logic [31:0] rd;
        int          a;
        xfer(1'b0, 2'd1, 32'h0, 4'hF, rd, a);
        check(name, rd, exp);
    endtask

    task automatic clear_mon();
        rise_q.delete();
        hi_q.delete();
    endtask

    task automatic check_cadence(input string name, input int n_exp);
        int bad = 0;
        check({name, "_rises"}, rise_q.size(), n_exp);
        check({name, "_highs"}, hi_q.size(), n_exp);
        for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 16) bad++;
        for (int i = 0; i < hi_q.size(); i++) if (hi_q[i] != 8) bad++;
        check({name, "_cadence_errors"}, bad, 0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_succ;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] rd;
        int          a;
        int          a0;

        vecs[0]  = '{1'b0, 2'd1, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 4'hF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b0, 2'd0, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b1};
        vecs[4]  = '{1'b1, 2'd0, 4'h2, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b1};
        vecs[6]  = '{1'b1, 2'd0, 4'hE, 32'h0000_0006, 1'b0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 2'd1, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 2'd2, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 2'd3, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 2'd3, 4'hF, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 2'd1, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 2'd0, 4'h1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 4'hF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};

        // Reset state
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_success", success_o, 0);
        check("rst_next", next_test_o, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Register table
        for (int i = 0; i < 15; i++) begin
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, a);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_success", i), success_o, vecs[i].exp_succ);
        end
        repeat (4) @(posedge wb_clk_i);
        #1;
        check("table_no_pulse", next_test_o, 0);

        // Single pulse: rise one cycle after ack, high 8 cycles
        clear_mon();
        wr(32'h2, a);
        @(posedge wb_clk_i);
        #1;
        check("a_ack_one_cycle", wb_ack_o, 0);
        check("a_dat_idle_zero", wb_dat_o, 0);
        repeat (30) @(posedge wb_clk_i);
        check_cadence("a", 1);
        if (rise_q.size() > 0) check("a_rise_latency", rise_q[0] - a, 1);
        rd_status("a_status", 32'h0001_0000);

        // Three back-to-back requests
        wr(32'h4, a);
        clear_mon();
        for (int i = 0; i < 3; i++) wr(32'h2, a);
        repeat (60) @(posedge wb_clk_i);
        check_cadence("b", 3);
        rd_status("b_status", 32'h0003_0000);

        // SUCCESS and NEXT together: success leads the rise
        clear_mon();
        wr(32'h3, a);
        check("d_success_at_ack", success_o, 1);
        check("d_next_low_at_ack", next_test_o, 0);
        @(posedge wb_clk_i);
        #1;
        check("d_next_high", next_test_o, 1);
        check("d_success_held", success_o, 1);
        repeat (30) @(posedge wb_clk_i);
        rd_status("d_status", 32'h0004_0000);
        wr(32'h5, a);

        // Request landing exactly on the GAP-end dequeue edge
        clear_mon();
        wr(32'h3, a0);
        wr(32'h3, a);
        #1;
        while (cyc < a0 + 16) begin
            @(posedge wb_clk_i);
            #1;
        end
        wr(32'h3, a);
        check("e_ack_on_dequeue_edge", a - a0, 17);
        rd_status("e_status", 32'h0002_0011);
        repeat (60) @(posedge wb_clk_i);
        check_cadence("e", 3);
        rd_status("e_status_end", 32'h0003_0000);
        wr(32'h5, a);

        // Saturation: one pulse in flight, then 19 more requests
        clear_mon();
        wr(32'h3, a);
        for (int i = 0; i < 19; i++) wr(32'h3, a);
        rd_status("c_status_sat", 32'h0003_00F3);
        repeat (300) @(posedge wb_clk_i);
        check_cadence("c", 18);
        rd_status("c_status_end", 32'h0012_0002);
        wr(32'h5, a);
        rd_status("c_status_clr", 32'h0000_0000);
        check("c_success_kept", success_o, 1);

        // Reset mid-HIGH with a request still queued
        wr(32'h3, a);
        wr(32'h3, a);
        #1;
        while (cyc < a + 4) begin
            @(posedge wb_clk_i);
            #1;
        end
        check("r_pre_reset_high", next_test_o, 1);
        @(negedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("r_next_cut", next_test_o, 0);
        check("r_success_cut", success_o, 0);
        check("r_ack_cut", wb_ack_o, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        clear_mon();
        repeat (40) @(posedge wb_clk_i);
        check("r_no_pulse_after", rise_q.size(), 0);
        rd_status("r_status", 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
